// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks the destination registers of the EXE/MEM/WB slots and
// raises a combinational stall for the instruction sitting in ID.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fwd_en,
    input  logic        freeze,
    input  logic        flush,
    input  logic        id_valid,
    input  logic        id_wb_en,
    input  logic        id_mem_r_en,
    input  logic [3:0]  id_dest,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    output logic        hazard,
    output logic [3:0]  exe_dest,
    output logic [3:0]  mem_dest,
    output logic [3:0]  wb_dest,
    output logic        exe_wb_en,
    output logic        mem_wb_en,
    output logic        wb_wb_en,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic [3:0] dest;
    } exe_slot_t;

    // Past EXE the load flag no longer affects any stall decision, so it is not carried.
    typedef struct packed {
        logic       wb_en;
        logic [3:0] dest;
    } slot_t;

    exe_slot_t   exe_q;
    exe_slot_t   exe_d;
    slot_t       mem_q;
    slot_t       wb_q;
    logic [15:0] stall_cnt_q;

    logic exe_hit;
    logic mem_hit;
    logic raw_hazard;

    always_comb begin
        exe_hit = exe_q.wb_en &&
                  ((id_src1 == exe_q.dest) || (id_two_src && (id_src2 == exe_q.dest)));
        mem_hit = mem_q.wb_en &&
                  ((id_src1 == mem_q.dest) || (id_two_src && (id_src2 == mem_q.dest)));
        if (fwd_en) begin
            raw_hazard = exe_hit && exe_q.mem_r_en;
        end else begin
            raw_hazard = exe_hit || mem_hit;
        end
        // WB never stalls: the register file is written in the first half-cycle.
        hazard = id_valid && !flush && raw_hazard;
    end

    always_comb begin
        exe_d = '0;
        if (id_valid && !hazard && !flush) begin
            exe_d.wb_en    = id_wb_en;
            exe_d.mem_r_en = id_wb_en && id_mem_r_en;
            exe_d.dest     = id_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else if (!freeze) begin
            wb_q        <= mem_q;
            mem_q.wb_en <= exe_q.wb_en;
            mem_q.dest  <= exe_q.dest;
            exe_q       <= exe_d;
            if (hazard && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign exe_dest    = exe_q.dest;
    assign exe_wb_en   = exe_q.wb_en;
    assign mem_dest    = mem_q.dest;
    assign mem_wb_en   = mem_q.wb_en;
    assign wb_dest     = wb_q.dest;
    assign wb_wb_en    = wb_q.wb_en;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, checked
// against a history-queue model through an expectation queue and a sampling monitor.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fwd_en = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_wb_en = 1'b0;
    logic        id_mem_r_en = 1'b0;
    logic [3:0]  id_dest = 4'd0;
    logic [3:0]  id_src1 = 4'd0;
    logic [3:0]  id_src2 = 4'd0;
    logic        id_two_src = 1'b0;
    logic        hazard;
    logic [3:0]  exe_dest, mem_dest, wb_dest;
    logic        exe_wb_en, mem_wb_en, wb_wb_en;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fwd_en     (fwd_en),
        .freeze     (freeze),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_wb_en   (id_wb_en),
        .id_mem_r_en(id_mem_r_en),
        .id_dest    (id_dest),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_two_src (id_two_src),
        .hazard     (hazard),
        .exe_dest   (exe_dest),
        .mem_dest   (mem_dest),
        .wb_dest    (wb_dest),
        .exe_wb_en  (exe_wb_en),
        .mem_wb_en  (mem_wb_en),
        .wb_wb_en   (wb_wb_en),
        .stall_count(stall_count)
    );

    typedef struct {
        bit       wb;
        bit       ld;
        bit [3:0] dest;
    } rec_t;

    typedef struct {
        string    nm;
        bit       haz;
        bit       ee, me, we;
        bit [3:0] ed, md, wd;
        bit [15:0] cnt;
    } exp_t;

    exp_t      exp_q[$];
    rec_t      hist[$];   // accepted instructions/bubbles, newest last
    bit [15:0] m_cnt = 16'd0;
    int        vectors = 0;
    int        miscompares = 0;

    function automatic rec_t age(int a);
        rec_t r;
        r.wb = 1'b0; r.ld = 1'b0; r.dest = 4'd0;
        if (hist.size() > a) r = hist[hist.size() - 1 - a];
        return r;
    endfunction

    function automatic bit dep(rec_t s, bit [3:0] a, bit [3:0] b, bit two);
        return s.wb && ((a == s.dest) || (two && (b == s.dest)));
    endfunction

    task automatic cyc(string nm, bit fe, bit fz, bit fl, bit v, bit wb, bit ld,
                       bit [3:0] d, bit [3:0] a, bit [3:0] b, bit two);
        exp_t e;
        rec_t ex, mm, ww, acc;
        bit   h;
        @(negedge clk);
        fwd_en = fe; freeze = fz; flush = fl; id_valid = v;
        id_wb_en = wb; id_mem_r_en = ld; id_dest = d;
        id_src1 = a; id_src2 = b; id_two_src = two;
        ex = age(0); mm = age(1); ww = age(2);
        if (!v || fl)  h = 1'b0;
        else if (fe)   h = ex.ld && dep(ex, a, b, two);
        else           h = dep(ex, a, b, two) || dep(mm, a, b, two);
        e.nm = nm; e.haz = h;
        e.ee = ex.wb; e.ed = ex.dest;
        e.me = mm.wb; e.md = mm.dest;
        e.we = ww.wb; e.wd = ww.dest;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        acc.wb = 1'b0; acc.ld = 1'b0; acc.dest = 4'd0;
        if (v && !h && !fl) begin
            acc.wb = wb; acc.ld = ld && wb; acc.dest = d;
        end
        @(posedge clk);
        if (!fz) begin
            hist.push_back(acc);
            if (hist.size() > 3) void'(hist.pop_front());
            if (h && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    // Asserts reset mid-cycle with ID inputs left as they were; the check lands before any edge.
    task automatic do_reset(string nm);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        hist.delete();
        m_cnt = 16'd0;
        e.nm = nm; e.haz = 1'b0;
        e.ee = 1'b0; e.ed = 4'd0; e.me = 1'b0; e.md = 4'd0; e.we = 1'b0; e.wd = 4'd0;
        e.cnt = 16'd0;
        exp_q.push_back(e);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Loads the stall counter near saturation during a frozen cycle.
    task automatic preset_count();
        @(negedge clk);
        freeze = 1'b1; id_valid = 1'b0; flush = 1'b0;
        force dut.stall_cnt_q = 16'hFFFD;
        #1 release dut.stall_cnt_q;
        m_cnt = 16'hFFFD;
        @(posedge clk);
    endtask

    function automatic bit [3:0] rreg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (hazard !== e.haz || exe_wb_en !== e.ee || exe_dest !== e.ed ||
                    mem_wb_en !== e.me || mem_dest !== e.md ||
                    wb_wb_en !== e.we || wb_dest !== e.wd || stall_count !== e.cnt) begin
                    miscompares++;
                    $display("FAIL %s: got hz=%0d exe=%0d:%0d mem=%0d:%0d wb=%0d:%0d cnt=%h, want hz=%0d exe=%0d:%0d mem=%0d:%0d wb=%0d:%0d cnt=%h",
                             e.nm, hazard, exe_wb_en, exe_dest, mem_wb_en, mem_dest,
                             wb_wb_en, wb_dest, stall_count, e.haz, e.ee, e.ed,
                             e.me, e.md, e.we, e.wd, e.cnt);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit fe;
        do_reset("por");

        // load-use with forwarding
        cyc("ldr_r3",        1, 0, 0, 1, 1, 1, 4'd3, 4'd0, 4'd0, 0);
        cyc("use_r3_stall",  1, 0, 0, 1, 1, 0, 4'd5, 4'd3, 4'd0, 0);
        cyc("use_r3_go",     1, 0, 0, 1, 1, 0, 4'd5, 4'd3, 4'd0, 0);
        cyc("after_ldr",     1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);

        // ALU result forwarded, no stall
        cyc("add_r4",        1, 0, 0, 1, 1, 0, 4'd4, 4'd0, 4'd0, 0);
        cyc("src2_r4_fwd",   1, 0, 0, 1, 1, 0, 4'd6, 4'd1, 4'd4, 1);
        cyc("src2_unused",   1, 0, 0, 1, 1, 0, 4'd8, 4'd5, 4'd4, 0);
        cyc("idle_a",        1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);

        // no forwarding: stall until producer reaches WB
        cyc("add_r2",        0, 0, 0, 1, 1, 0, 4'd2, 4'd0, 4'd0, 0);
        cyc("dep_r2_s1",     0, 0, 0, 1, 1, 0, 4'd9, 4'd2, 4'd0, 0);
        cyc("dep_r2_s2",     0, 0, 0, 1, 1, 0, 4'd9, 4'd2, 4'd0, 0);
        cyc("dep_r2_go",     0, 0, 0, 1, 1, 0, 4'd9, 4'd2, 4'd0, 0);
        repeat (3) cyc("idle_b", 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);

        // freeze holds everything, flush overrides hazard
        cyc("add_r7",        0, 0, 0, 1, 1, 0, 4'd7, 4'd0, 4'd0, 0);
        cyc("r7_to_mem",     0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
        repeat (3) cyc("freeze_r7", 0, 1, 0, 1, 1, 0, 4'd1, 4'd7, 4'd0, 0);
        cyc("flush_r7",      0, 0, 1, 1, 1, 0, 4'd1, 4'd7, 4'd0, 0);
        repeat (2) cyc("idle_c", 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);

        // counter saturation, register 15 as ordinary operand
        preset_count();
        cyc("sat_w15",       0, 0, 0, 1, 1, 0, 4'd15, 4'd0, 4'd0, 0);
        repeat (3) cyc("sat_dep15", 0, 0, 0, 1, 1, 0, 4'd1, 4'd0, 4'd15, 1);
        repeat (3) cyc("sat_dep1",  0, 0, 0, 1, 1, 0, 4'd2, 4'd1, 4'd0, 0);
        cyc("sat_hold",      0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);

        // reset with three live slots and a pending hazard
        cyc("fill_r1",       0, 0, 0, 1, 1, 0, 4'd1, 4'd0, 4'd0, 0);
        cyc("fill_r2",       0, 0, 0, 1, 1, 1, 4'd2, 4'd0, 4'd0, 0);
        cyc("fill_r3",       0, 0, 0, 1, 1, 0, 4'd3, 4'd0, 4'd0, 0);
        cyc("pre_reset",     0, 0, 0, 1, 1, 0, 4'd4, 4'd3, 4'd2, 1);
        do_reset("mid_reset");
        cyc("post_reset",    0, 0, 0, 1, 1, 0, 4'd4, 4'd3, 4'd2, 1);

        fe = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) fe = ~fe;
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand_reset");
            end else begin
                cyc("random", fe,
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 80,
                    $urandom_range(0, 99) < 75,
                    $urandom_range(0, 99) < 35,
                    rreg(), rreg(), rreg(),
                    $urandom_range(0, 1) == 1);
            end
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
